edge_pulse_gen: RTL

//  Transmit side of the edge-detect path: converts single-cycle trigger requests into

---
 rtl/edge_pulse_gen_if.sv | 27 ++
 rtl/edge_pulse_gen.sv | 105 ++++++++++
 2 files changed

// File: rtl/edge_pulse_gen_if.sv
// Trigger/length inputs and shaped-pulse status outputs of the edge pulse generator.
// The master side issues triggers and lengths; the slave side is the generator.
interface edge_pulse_gen_if #(
    parameter int CNT_W       = 8,
    parameter int MAX_PENDING = 4
);
    localparam int PW = $clog2(MAX_PENDING + 1);

    logic             trig;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic             dout;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [PW-1:0]    pend_cnt;

    modport master (
        output trig, high_len, low_len,
        input  dout, busy, done, overflow, pend_cnt
    );

    modport slave (
        input  trig, high_len, low_len,
        output dout, busy, done, overflow, pend_cnt
    );
endinterface

// File: rtl/edge_pulse_gen.sv
// Turns single-cycle trigger requests into high/low shaped pulses on dout, queueing
// requests that arrive mid-pulse and flagging one-cycle done after each falling edge.
module edge_pulse_gen #(
    parameter int CNT_W       = 8,
    parameter int MAX_PENDING = 4
) (
    input  logic             clk,
    input  logic             resetn,
    edge_pulse_gen_if.slave  bus
);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] low_len_reg;
    logic [PW-1:0]    pend_reg;
    logic             dout_reg;
    logic             dout_d_reg;
    logic             done_reg;
    logic             overflow_reg;

    logic             last_low;
    logic             dequeue;
    logic             accept;
    logic             start;
    logic [CNT_W-1:0] high_m1;
    logic [CNT_W-1:0] low_m1;

    // The counter holds "cycles remaining minus one", so zero marks the final cycle.
    assign high_m1  = (bus.high_len == '0) ? '0 : bus.high_len - 1'b1;
    assign low_m1   = (bus.low_len  == '0) ? '0 : bus.low_len  - 1'b1;
    assign last_low = (state_reg == LOW) && (cnt_reg == '0);
    assign dequeue  = last_low && (pend_reg != '0);
    assign accept   = bus.trig && ((state_reg == IDLE) || (last_low && (pend_reg == '0)));
    assign start    = accept || dequeue;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            low_len_reg  <= '0;
            pend_reg     <= '0;
            dout_reg     <= 1'b0;
            dout_d_reg   <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            dout_d_reg   <= dout_reg;
            done_reg     <= dout_d_reg & ~dout_reg;
            overflow_reg <= 1'b0;

            if (start) begin
                state_reg   <= HIGH;
                dout_reg    <= 1'b1;
                cnt_reg     <= high_m1;
                low_len_reg <= low_m1;
            end else begin
                case (state_reg)
                    HIGH: begin
                        if (cnt_reg == '0) begin
                            state_reg <= LOW;
                            dout_reg  <= 1'b0;
                            cnt_reg   <= low_len_reg;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    LOW: begin
                        if (cnt_reg == '0) begin
                            state_reg <= IDLE;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        dout_reg  <= 1'b0;
                    end
                endcase
            end

            // A trigger coinciding with a dequeue takes the freed slot, so the count holds.
            if (bus.trig && !accept) begin
                if (!dequeue) begin
                    if (pend_reg < PEND_MAX) begin
                        pend_reg <= pend_reg + 1'b1;
                    end else begin
                        overflow_reg <= 1'b1;
                    end
                end
            end else if (dequeue) begin
                pend_reg <= pend_reg - 1'b1;
            end
        end
    end

    assign bus.dout     = dout_reg;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.done     = done_reg;
    assign bus.overflow = overflow_reg;
    assign bus.pend_cnt = pend_reg;
endmodule
